// File: rtl/pixel_unpacker_pkg.sv
// Shared encodings and constants for the pixel path: display modes, the
// pixels-per-word rule and the packed RGB triple.
package pixel_unpacker_pkg;

  typedef enum logic [1:0] {
    MODE_8BIT     = 2'b00,
    MODE_1BIT     = 2'b01,
    MODE_8BIT_ALT = 2'b10,
    MODE_16BIT    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_e;

  localparam int              PL_W      = 4;
  localparam logic [PL_W-1:0] PPW_1BIT  = 4'd8;
  localparam logic [PL_W-1:0] PPW_OTHER = 4'd1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [PL_W-1:0] pixels_per_word(input mode_e m);
    return (m == MODE_1BIT) ? PPW_1BIT : PPW_OTHER;
  endfunction

endpackage

// File: rtl/pixel_unpacker_if.sv
// Pixel-side bundle: FIFO head/pop, VGA request and registered colour/status.
// master drives the requests and FIFO head; slave is the unpacker.
interface pixel_unpacker_if;
  logic [1:0]  iMODE;
  logic        iFRAME_START;
  logic        iENABLE;
  logic [15:0] iWORD;
  logic        iWORD_VALID;
  logic        oWORD_RD;
  logic        iREQ;
  logic [7:0]  oR;
  logic [7:0]  oG;
  logic [7:0]  oB;
  logic        oVALID;
  logic        oUNDERRUN;
  logic [15:0] oUNDER_CNT;

  modport master (
    output iMODE, iFRAME_START, iENABLE, iWORD, iWORD_VALID, iREQ,
    input  oWORD_RD, oR, oG, oB, oVALID, oUNDERRUN, oUNDER_CNT
  );

  modport slave (
    input  iMODE, iFRAME_START, iENABLE, iWORD, iWORD_VALID, iREQ,
    output oWORD_RD, oR, oG, oB, oVALID, oUNDERRUN, oUNDER_CNT
  );
endinterface

// File: rtl/pixel_colour_map.sv
// Combinational word-to-colour mapping for the active mode.
// bit_sel_i picks the packed bit in 1-bit mode (7 for the first pixel).
module pixel_colour_map
  import pixel_unpacker_pkg::*;
(
  input  mode_e       mode_i,
  input  logic [15:0] word_i,
  input  logic [2:0]  bit_sel_i,
  output rgb_t        rgb_o
);

  always_comb begin
    rgb_o = '0;
    case (mode_i)
      MODE_1BIT:  rgb_o = {24{word_i[bit_sel_i]}};
      MODE_16BIT: begin
        rgb_o.r = {word_i[7:3], word_i[7:5]};
        rgb_o.g = {word_i[2:0], word_i[15:13], word_i[2:1]};
        rgb_o.b = {word_i[12:8], word_i[12:10]};
      end
      default: begin
        rgb_o.r = word_i[7:0];
        rgb_o.g = word_i[7:0];
        rgb_o.b = word_i[7:0];
      end
    endcase
  end

endmodule

// File: rtl/pixel_unpacker.sv
// Unpacks FIFO words into one pixel per VGA request, one cycle after the request.
// The FIFO pop is combinational with the load so consecutive words leave no gap.
module pixel_unpacker
  import pixel_unpacker_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRST_N,
  pixel_unpacker_if.slave  bus
);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [15:0]     w_q, w_d;
  logic [PL_W-1:0] pl_q, pl_d;
  rgb_t            rgb_q, rgb_d;
  logic            vld_q, vld_d;
  logic            under_q, under_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            pop;
  logic [2:0]      bit_sel;
  rgb_t            px;

  // Pixel k of a 1-bit word is W[7-k], and with PL pixels left k = 8-PL.
  assign bit_sel = pl_q[2:0] - 3'd1;

  pixel_colour_map u_map (
    .mode_i    (mode_q),
    .word_i    (w_q),
    .bit_sel_i (bit_sel),
    .rgb_o     (px)
  );

  always_comb begin
    mode_d  = mode_q;
    w_d     = w_q;
    pl_d    = pl_q;
    rgb_d   = '0;
    vld_d   = bus.iREQ;
    under_d = under_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;

    if (bus.iFRAME_START) begin
      // Frame boundary wins over a coincident request: flush without popping.
      mode_d = mode_e'(bus.iMODE);
      pl_d   = '0;
    end else begin
      if (state_q == ST_EMPTY) begin
        if (bus.iREQ) begin
          under_d = 1'b1;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end else if (bus.iREQ) begin
        pl_d = pl_q - 4'd1;
        if (bus.iENABLE) rgb_d = px;
      end

      if (bus.iWORD_VALID &&
          (state_q == ST_EMPTY || (pl_q == 4'd1 && bus.iREQ))) begin
        pop  = 1'b1;
        w_d  = bus.iWORD;
        pl_d = pixels_per_word(mode_q);
      end
    end

    state_d = (pl_d == '0) ? ST_EMPTY : ST_LOADED;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= ST_EMPTY;
      mode_q  <= MODE_8BIT;
      w_q     <= '0;
      pl_q    <= '0;
      rgb_q   <= '0;
      vld_q   <= 1'b0;
      under_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      w_q     <= w_d;
      pl_q    <= pl_d;
      rgb_q   <= rgb_d;
      vld_q   <= vld_d;
      under_q <= under_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.oWORD_RD   = pop & iRST_N;
  assign bus.oR         = rgb_q.r;
  assign bus.oG         = rgb_q.g;
  assign bus.oB         = rgb_q.b;
  assign bus.oVALID     = vld_q;
  assign bus.oUNDERRUN  = under_q;
  assign bus.oUNDER_CNT = cnt_q;

endmodule
